// File: rtl/hqc_pkg.sv
// Shared HQC constants: per-parameter-set sizes, vector RAM geometry helpers
// and the state encoding of the location-to-vector expander.
package hqc_pkg;

    function automatic int hqc_n(input string ps);
        if (ps == "hqc192") return 35851;
        if (ps == "hqc256") return 57637;
        return 17669;
    endfunction

    function automatic int hqc_m(input string ps);
        if (ps == "hqc192") return 16;
        if (ps == "hqc256") return 16;
        return 15;
    endfunction

    function automatic int hqc_weight(input string ps);
        if (ps == "hqc192") return 114;
        if (ps == "hqc256") return 149;
        return 75;
    endfunction

    // Number of WIDTH-bit words needed to hold an n-bit vector.
    function automatic int vec_depth(input int n, input int width);
        return (n + width - 1) / width;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_EXPAND = 2'd2,
        ST_DRAIN  = 2'd3
    } l2v_state_t;

endpackage

// File: rtl/mem_dual.sv
// Dual-port word RAM with 1-cycle registered reads.
// Port A carries the expander's read and write (distinct addresses, same
// cycle); a read that hits the word being written returns the old contents.
// Port B is a read-only external port.
module mem_dual #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 553,
    parameter int LOG_DEPTH = 10
) (
    input  logic                 clk,
    input  logic                 i_a_we,
    input  logic [LOG_DEPTH-1:0] i_a_waddr,
    input  logic [WIDTH-1:0]     i_a_wdata,
    input  logic                 i_a_re,
    input  logic [LOG_DEPTH-1:0] i_a_raddr,
    output logic [WIDTH-1:0]     o_a_rdata,
    input  logic                 i_b_re,
    input  logic [LOG_DEPTH-1:0] i_b_addr,
    output logic [WIDTH-1:0]     o_b_rdata
);

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [WIDTH-1:0] r_a_rdata;
    logic [WIDTH-1:0] r_b_rdata;

    // Port A write plus registered reads on both ports.
    always_ff @(posedge clk) begin
        if (i_a_we) r_mem[i_a_waddr] <= i_a_wdata;
        if (i_a_re) r_a_rdata <= r_mem[i_a_raddr];
        if (i_b_re) r_b_rdata <= r_mem[i_b_addr];
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/loc_to_vector.sv
// Expands WEIGHT error locations into a dense N-bit vector held in a word RAM.
// Sequence: CLEAR zeroes every word, EXPAND streams location reads, a
// two-stage read-modify-write pipeline sets one bit per location, DRAIN lets
// the pipeline empty before done pulses.
// Handshake: rd_error_loc/rd_addr_error_loc issue a read whose data appears on
// error_loc exactly one cycle later; rd_e/rd_addr_e return error one cycle later.
module loc_to_vector
    import hqc_pkg::*;
#(
    parameter string parameter_set = "hqc128",
    parameter int N          = hqc_n(parameter_set),
    parameter int M          = hqc_m(parameter_set),
    parameter int WEIGHT     = hqc_weight(parameter_set),
    parameter int WIDTH      = 32,
    parameter int LOG_WEIGHT = $clog2(WEIGHT),
    parameter int DEPTH      = vec_depth(N, WIDTH),
    parameter int LOG_DEPTH  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_error_loc,
    output logic [LOG_WEIGHT-1:0] rd_addr_error_loc,
    input  logic [M-1:0]          error_loc,
    input  logic                  rd_e,
    input  logic [LOG_DEPTH-1:0]  rd_addr_e,
    output logic [WIDTH-1:0]      error,
    output logic                  busy,
    output logic                  done,
    output logic                  loc_err,
    output logic [1:0]            dbg_state
);

    localparam int CTR_W     = (LOG_DEPTH > LOG_WEIGHT) ? LOG_DEPTH : LOG_WEIGHT;
    localparam int LOG_WIDTH = $clog2(WIDTH);

    l2v_state_t r_state, w_state_nxt;
    logic [CTR_W-1:0] r_ctr, w_ctr_nxt;
    logic r_busy, w_busy_nxt;
    logic r_done, w_done_nxt;
    logic r_loc_err, w_err_clr;
    logic w_rd_loc, w_clr_we;

    // Pipeline registers: S1 holds the arriving location, S2 the write-back.
    logic                 r_s1_valid;
    logic                 r_s2_valid;
    logic [LOG_DEPTH-1:0] r_s2_word;
    logic [WIDTH-1:0]     r_s2_mask;
    logic                 r_s2_fwd;
    logic [WIDTH-1:0]     r_fwd_data;

    logic [LOG_DEPTH-1:0] w_s1_word;
    logic [LOG_WIDTH-1:0] w_s1_bit;
    logic                 w_s1_oor;
    logic [WIDTH-1:0]     w_a_rdata;
    logic [WIDTH-1:0]     w_s2_wdata;
    logic                 w_a_we;
    logic [LOG_DEPTH-1:0] w_a_waddr;
    logic [WIDTH-1:0]     w_a_wdata;

    assign w_s1_word = LOG_DEPTH'(error_loc / M'(WIDTH));
    assign w_s1_bit  = LOG_WIDTH'(error_loc % M'(WIDTH));
    assign w_s1_oor  = 32'(error_loc) >= 32'(N);

    // A word just written by S2 is stale in the RAM read, so use the forwarded copy.
    assign w_s2_wdata = (r_s2_fwd ? r_fwd_data : w_a_rdata) | r_s2_mask;

    assign w_a_we    = w_clr_we | r_s2_valid;
    assign w_a_waddr = w_clr_we ? LOG_DEPTH'(r_ctr) : r_s2_word;
    assign w_a_wdata = w_clr_we ? '0 : w_s2_wdata;

    // FSM state, sequencing counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ctr     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_loc_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ctr   <= w_ctr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_err_clr)
                r_loc_err <= 1'b0;
            else if (r_s1_valid && w_s1_oor)
                r_loc_err <= 1'b1;
        end
    end

    // Next-state, counter and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_ctr_nxt   = r_ctr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_clr   = 1'b0;
        w_rd_loc    = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                    w_ctr_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_err_clr   = 1'b1;
                end
            end
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_ctr == CTR_W'(DEPTH - 1)) begin
                    w_state_nxt = ST_EXPAND;
                    w_ctr_nxt   = '0;
                end else begin
                    w_ctr_nxt = r_ctr + CTR_W'(1);
                end
            end
            ST_EXPAND: begin
                w_rd_loc = 1'b1;
                if (r_ctr == CTR_W'(WEIGHT - 1)) begin
                    w_state_nxt = ST_DRAIN;
                    w_ctr_nxt   = '0;
                end else begin
                    w_ctr_nxt = r_ctr + CTR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_ctr == CTR_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_ctr_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ctr_nxt = r_ctr + CTR_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read-modify-write pipeline; out-of-range locations never reach S2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_fwd   <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_loc;
            r_s2_valid <= r_s1_valid && !w_s1_oor;
            r_s2_fwd   <= r_s2_valid && (w_s1_word == r_s2_word);
        end
        r_s2_word  <= w_s1_word;
        r_s2_mask  <= WIDTH'(1) << w_s1_bit;
        r_fwd_data <= w_s2_wdata;
    end

    mem_dual #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_mem (
        .clk       (clk),
        .i_a_we    (w_a_we),
        .i_a_waddr (w_a_waddr),
        .i_a_wdata (w_a_wdata),
        .i_a_re    (r_s1_valid),
        .i_a_raddr (w_s1_word),
        .o_a_rdata (w_a_rdata),
        .i_b_re    (rd_e),
        .i_b_addr  (rd_addr_e),
        .o_b_rdata (error)
    );

    assign rd_error_loc      = w_rd_loc;
    assign rd_addr_error_loc = LOG_WEIGHT'(r_ctr);
    assign busy              = r_busy;
    assign done              = r_done;
    assign loc_err           = r_loc_err;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_loc_to_vector.sv
// Bench for loc_to_vector (hqc128 sizes): location memory model, bit-level
// reference vector, read-back scoreboard and timing checks.
module tb_loc_to_vector;
    import hqc_pkg::*;

    localparam int N          = 17669;
    localparam int M          = 15;
    localparam int WEIGHT     = 75;
    localparam int WIDTH      = 32;
    localparam int DEPTH      = 553;
    localparam int LOG_WEIGHT = 7;
    localparam int LOG_DEPTH  = 10;
    localparam int LATENCY    = DEPTH + WEIGHT + 3;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  rd_error_loc;
    logic [LOG_WEIGHT-1:0] rd_addr_error_loc;
    logic [M-1:0]          error_loc;
    logic                  rd_e;
    logic [LOG_DEPTH-1:0]  rd_addr_e;
    logic [WIDTH-1:0]      error;
    logic                  busy;
    logic                  done;
    logic                  loc_err;
    logic [1:0]            dbg_state;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               addr_q[$];

    logic [M-1:0] loc_mem [WEIGHT];
    bit           exp_vec [DEPTH*WIDTH];
    bit           exp_err;

    loc_to_vector dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .rd_error_loc      (rd_error_loc),
        .rd_addr_error_loc (rd_addr_error_loc),
        .error_loc         (error_loc),
        .rd_e              (rd_e),
        .rd_addr_e         (rd_addr_e),
        .error             (error),
        .busy              (busy),
        .done              (done),
        .loc_err           (loc_err),
        .dbg_state         (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // location memory: data one cycle after the read enable
    always @(posedge clk)
        if (rd_error_loc) error_loc <= loc_mem[rd_addr_error_loc];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // reference: set bit loc of an all-zero vector for each in-range location
    task automatic build_model();
        for (int i = 0; i < DEPTH*WIDTH; i++) exp_vec[i] = 1'b0;
        exp_err = 1'b0;
        for (int i = 0; i < WEIGHT; i++) begin
            if (int'(loc_mem[i]) < N) exp_vec[int'(loc_mem[i])] = 1'b1;
            else exp_err = 1'b1;
        end
    endtask

    function automatic logic [WIDTH-1:0] exp_word(input int w);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) r[b] = exp_vec[w*WIDTH + b];
        return r;
    endfunction

    // four listed locations, remaining slots repeat the first (idempotent)
    task automatic load_set(input int a, input int b, input int c, input int d);
        loc_mem[0] = M'(a);
        loc_mem[1] = M'(b);
        loc_mem[2] = M'(c);
        loc_mem[3] = M'(d);
        for (int i = 4; i < WEIGHT; i++) loc_mem[i] = M'(a);
    endtask

    // random set clustered on a few words, occasional out-of-range entry
    task automatic load_random(input bit allow_oor);
        int base;
        base = $urandom_range(0, N - 64);
        for (int i = 0; i < WEIGHT; i++) begin
            if (allow_oor && $urandom_range(0, 19) == 0)
                loc_mem[i] = M'($urandom_range(N, 32767));
            else if ($urandom_range(0, 2) == 0)
                loc_mem[i] = M'($urandom_range(0, N - 1));
            else
                loc_mem[i] = M'(base + $urandom_range(0, 63));
        end
    endtask

    // scoreboard monitor: error is valid the cycle after rd_e is sampled
    logic mon_pend = 1'b0;
    always @(posedge clk) mon_pend <= rd_e;
    always @(negedge clk) begin
        if (mon_pend) begin
            if (exp_q.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                automatic logic [WIDTH-1:0] e = exp_q.pop_front();
                automatic int a = addr_q.pop_front();
                check($sformatf("word%0d", a), error, e);
            end
        end
    end

    task automatic read_all(input string tag);
        int guard;
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            rd_e      = 1'b1;
            rd_addr_e = LOG_DEPTH'(a);
            exp_q.push_back(exp_word(a));
            addr_q.push_back(a);
        end
        @(negedge clk);
        rd_e = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            addr_q.delete();
        end
    endtask

    // start, measure latency, check status, then compare every word
    task automatic run_vector(input bit poke, input string tag);
        int cyc;
        bit seen;
        build_model();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        seen = 1'b0;
        while (!seen && cyc < LATENCY + 50) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = (poke && cyc == 100);
                @(posedge clk);
                #1 cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(LATENCY));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1 check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_loc_err"}, 32'(loc_err), 32'(exp_err));
        read_all(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        rst       = 1'b1;
        start     = 1'b0;
        rd_e      = 1'b0;
        rd_addr_e = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_loc", 32'(rd_error_loc), 32'd0);
        check("rst_rd_addr", 32'(rd_addr_error_loc), 32'd0);
        check("rst_loc_err", 32'(loc_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        load_set(0, 31, 32, 17668);
        run_vector(1'b0, "edges");
        load_set(5, 6, 7, 8);
        run_vector(1'b0, "fwd");
        load_set(100, 100, 100, 100);
        run_vector(1'b0, "dup");
        load_set(1, 2, 3, 17669);
        run_vector(1'b0, "oor");
        load_random(1'b0);
        run_vector(1'b1, "rand_busy_start");

        // reset in the middle of EXPAND, then a fresh run
        load_random(1'b1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (DEPTH + 20) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) pulses++;
            @(posedge clk);
            #1;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        load_random(1'b1);
        run_vector(1'b0, "after_rst");

        for (int k = 0; k < 3; k++) begin
            load_random(1'b1);
            run_vector(1'b0, $sformatf("rand%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/loc_to_vector.md
Name: loc_to_vector

Overview:
- Reads the WEIGHT error locations that fixed_weight_cww stores in its location memory.
- Expands them into a dense N-bit error vector held in an internal word RAM of WIDTH-bit words.
- Bit i of the vector is bit (i mod WIDTH) of word floor(i/WIDTH).
- Sits between fixed_weight_cww and the polynomial multiplier/adder, which read the vector through the error/rd_e/rd_addr_e port.

Parameters:
- parameter_set, "hqc128", selects N/M/WEIGHT defaults as elsewhere in the HQC tree
- N, 17669, vector length in bits
- M, 15, location width in bits
- WEIGHT, 75, number of locations to read
- WIDTH, 32, vector RAM word width
- LOG_WEIGHT, CLOG2(WEIGHT), location address width
- DEPTH, (N+WIDTH-1)/WIDTH, vector RAM depth (553 for hqc128)
- LOG_DEPTH, CLOG2(DEPTH), vector address width

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin clear+expand; sampled only in IDLE
- rd_error_loc  out  1  read enable to location memory
- rd_addr_error_loc  out  LOG_WEIGHT  location memory address
- error_loc  in  M  location data, valid exactly 1 cycle after rd_error_loc
- rd_e  in  1  external read enable
- rd_addr_e  in  LOG_DEPTH  external word address
- error  out  WIDTH  vector word, valid 1 cycle after rd_e
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the vector is complete
- loc_err  out  1  sticky; set when any location >= N; cleared on start

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- Reset values: rd_error_loc=0, rd_addr_error_loc=0, busy=0, done=0, loc_err=0, FSM=IDLE. RAM contents are not reset.
- FSM states: IDLE -> CLEAR -> EXPAND -> DRAIN -> IDLE.
  - IDLE: start=1 -> CLEAR; clear counter=0, loc_err=0, busy=1.
  - CLEAR: write 0 to word ctr, one word per cycle, for DEPTH cycles. After word DEPTH-1 -> EXPAND with location counter=0.
  - EXPAND: rd_error_loc=1, rd_addr_error_loc=ctr each cycle, WEIGHT cycles. After address WEIGHT-1 -> DRAIN.
  - DRAIN: 2 cycles to empty the pipeline, then done=1 for one cycle, busy=0, -> IDLE.
- Expand pipeline, one location per cycle:
  - S1: error_loc arrives. Word address = loc/WIDTH, bit = loc%WIDTH. Issue RAM read on port A.
  - S2: RAM data ORed with one-hot(bit), written back on port A.
- Hazard forwarding: if S1's word equals the word S2 is writing in the same cycle, S1 takes S2's write data instead of stale RAM data. Back-to-back hits on one word must accumulate all bits.
- Duplicate locations are idempotent (OR).
- Out-of-range: loc >= N sets loc_err; the write for that location is suppressed; the vector is otherwise unaffected. Padding bits N..DEPTH*WIDTH-1 stay 0.
- Latency: done asserts exactly DEPTH+WEIGHT+3 cycles after the cycle start is sampled (631 for hqc128).
- start while busy is ignored.
- rst mid-operation: return to IDLE immediately; no done pulse; RAM content undefined until the next start completes.
- External port B is read-only, usable any time. Data read while busy=1 is undefined.
- No write-port collision is possible: port B never writes.

Decomposition:
- Shared package hqc_pkg holds:
  - per-parameter-set constants N, M, WEIGHT
  - WIDTH/DEPTH derivation
  - FSM state encoding (IDLE/CLEAR/EXPAND/DRAIN)
- One sub-module: mem_dual, a true dual-port RAM with 1-cycle registered reads.
  - Port A: FSM read/write.
  - Port B: external read.

Test Plan:
- WEIGHT=4 override, locations {0,31,32,17668}: word0=0x80000001, word1=0x00000001, word552=0x00000010, all other words 0, loc_err=0.
- Same-word back-to-back {5,6,7,8}: word0=0x000001E0 (forwarding check).
- Duplicates {100,100,100,100}: word3=0x00000010, total popcount 1.
- Location 17669 among {1,2,3,17669}: loc_err=1, word0=0x0000000E, word552=0.
- Timing and restart checks:
  - Full hqc128 run: done exactly 631 cycles after start.
  - Second start with a different location set: prior bits fully cleared.
  - rst asserted mid-EXPAND, then start: correct vector, no stale done pulse.
